gen_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares a single downstream resource among N requesters.
- Per-requester request/grant logic is built with genvar-indexed generate loops, one slice per requester.
- Sits between N client ports and a shared register/datapath slice. It sequences exclusive ownership: grant, hold, release, rotate.
- Intended for formal property checking as well as simulation, so all outputs are fully determined every cycle.

---
 rtl/arb_pkg.sv | 30 +++
 rtl/rr_pick.sv | 40 ++++
 rtl/gen_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_gen_rr_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
// The ownership hold limit in gen_rr_arbiter is compiled in only when
// ARB_HOLD_LIMIT_EN is defined.
package arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Default parameter values
    localparam int ARB_N_DEF        = 4;
    localparam int ARB_IDW_DEF      = 2;
    localparam int ARB_HOLD_MAX_DEF = 8;

    // Ceiling log2 for sizing counters at elaboration time
    function automatic int arb_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit
// scanning from ptr upward, wrapping modulo N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] win
);

    // Doubling the vector lets ptr+i index past N without a modulo.
    logic [2*N-1:0] dbl;
    logic [N-1:0]   cand;
    logic [IDW-1:0] pos [N];

    assign dbl = {req, req};

    // One slice per scan offset: candidate bit and its wrapped requester index
    for (genvar g = 0; g < N; g++) begin : g_slice
        logic [IDW:0] sum;
        assign sum     = {1'b0, ptr} + (IDW+1)'(g);
        assign cand[g] = dbl[sum];
        assign pos[g]  = IDW'((sum >= (IDW+1)'(N)) ? (sum - (IDW+1)'(N)) : sum);
    end

    // Lowest scan offset with a candidate wins
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                any = 1'b1;
                win = pos[i];
            end
        end
    end

endmodule

// File: rtl/gen_rr_arbiter.sv
// Round-robin arbiter for N requesters sharing one resource.
// Sequence: IDLE (arbitrate) -> OWN (hold until done/withdraw) ->
// RELEASE (one turnaround cycle) -> IDLE.
// Define ARB_HOLD_LIMIT_EN to force release after HOLD_MAX owned cycles.
//
// Handshake: a requester holds req[i] high until it sees gnt[i]; it keeps
// req[i] high for as long as it wants ownership and ends ownership either by
// pulsing done (while gnt_valid=1) or by dropping req[i]. Either ends the
// grant on the next edge; done outside ownership is ignored.
module gen_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int IDW      = ARB_IDW_DEF,
    parameter int HOLD_MAX = ARB_HOLD_MAX_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output arb_state_t     state_dbg
);

    if (N < 2 || N > 32 || (2 ** IDW) < N || HOLD_MAX < 1) begin : g_cfg_error
        $error("gen_rr_arbiter: invalid parameter combination");
    end

    arb_state_t     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q,   ptr_d;

    logic           pick_any;
    logic [IDW-1:0] pick_win;
    logic [IDW-1:0] next_ptr;
    logic           hold_limit;
    logic           release_now;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .win (pick_win)
    );

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HCW = arb_clog2(HOLD_MAX + 1);

    logic [HCW-1:0] hold_q, hold_d;

    // Ownership counter: zero outside OWN, counts owned cycles inside
    always_comb begin
        hold_d = '0;
        if (state_q == OWN) begin
            hold_d = hold_q + HCW'(1);
        end
    end

    // Ownership counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign hold_limit = (state_q == OWN) && (hold_q == HCW'(HOLD_MAX - 1));
`else
    assign hold_limit = 1'b0;
`endif

    // Wrap is an explicit compare so non-power-of-two N rotates correctly
    assign next_ptr    = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);
    assign release_now = done | ~req[owner_q] | hold_limit;

    // Next-state logic: arbitrate in IDLE, hold in OWN, one-cycle turnaround
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = OWN;
                    owner_d = pick_win;
                end
            end
            OWN: begin
                if (release_now) begin
                    state_d = RELEASE;
                    ptr_d   = next_ptr;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, owner and rotation pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Per-requester grant slice: asserted only for the owner while in OWN
    for (genvar g = 0; g < N; g++) begin : g_gnt
        assign gnt[g] = (state_q == OWN) && (owner_q == IDW'(g));
    end

    assign gnt_valid = |gnt;
    assign gnt_id    = (state_q == OWN) ? owner_q : '0;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_gen_rr_arbiter.sv
// Directed self-checking bench for gen_rr_arbiter (N=4, HOLD_MAX=8).
module tb_gen_rr_arbiter;
    import arb_pkg::*;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int HOLD_MAX = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    arb_state_t     state_dbg;

    int checks;
    int errors;
    logic [IDW-1:0] exp_q[$];

    gen_rr_arbiter #(
        .N        (N),
        .IDW      (IDW),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all grant outputs against a hand-derived expectation
    task automatic check_out(input string tag, input logic [N-1:0] e_gnt,
                             input logic [IDW-1:0] e_id, input logic e_busy);
        logic e_valid;
        e_valid = (e_gnt != '0);
        checks++;
        assert (gnt === e_gnt && gnt_id === e_id && busy === e_busy && gnt_valid === e_valid)
        else begin
            errors++;
            $error("FAIL %s: got gnt=%b id=%0d busy=%b valid=%b, expected gnt=%b id=%0d busy=%b valid=%b",
                   tag, gnt, gnt_id, busy, gnt_valid, e_gnt, e_id, e_busy, e_valid);
        end
    endtask

    task automatic check_state(input string tag, input arb_state_t e_state);
        checks++;
        assert (state_dbg === e_state)
        else begin
            errors++;
            $error("FAIL %s: got state=%0d, expected state=%0d", tag, state_dbg, e_state);
        end
    endtask

    // Expected grant to requester `id`
    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;

        // Reset with all requests high: nothing granted
        tick();
        check_out("reset_c0", 4'b0000, 2'd0, 1'b0);
        check_state("reset_c0_state", IDLE);
        tick();
        check_out("reset_c1", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        check_out("post_reset", 4'b0000, 2'd0, 1'b0);

        // First arbitration after reset starts from ptr=0
        tick();
        check_out("first_grant", onehot(0), 2'd0, 1'b1);
        done = 1'b1;
        tick();
        check_out("first_release", 4'b0000, 2'd0, 1'b1);
        check_state("first_release_state", RELEASE);
        done = 1'b0;
        req  = 4'b0000;
        tick();
        check_out("idle_no_req", 4'b0000, 2'd0, 1'b0);

        // Single requester 2: grant latency 1, hold, release via done
        req = 4'b0100;
        tick();
        check_out("req2_c1", onehot(2), 2'd2, 1'b1);
        tick();
        check_out("req2_c2", onehot(2), 2'd2, 1'b1);
        tick();
        check_out("req2_c3", onehot(2), 2'd2, 1'b1);
        done = 1'b1;
        tick();
        check_out("req2_c4_release", 4'b0000, 2'd0, 1'b1);
        check_state("req2_c4_state", RELEASE);
        done = 1'b0;
        req  = 4'b0000;
        tick();
        check_out("req2_c5_idle", 4'b0000, 2'd0, 1'b0);
        check_state("req2_c5_state", IDLE);

        // ptr=3: requester 3 wins over 0, then ptr wraps to 0
        req = 4'b1001;
        tick();
        check_out("wrap_grant3", onehot(3), 2'd3, 1'b1);
        done = 1'b1;
        tick();
        check_out("wrap_release", 4'b0000, 2'd0, 1'b1);
        done = 1'b0;
        tick();
        check_out("wrap_idle", 4'b0000, 2'd0, 1'b0);
        tick();
        check_out("wrap_grant0", onehot(0), 2'd0, 1'b1);

        // done and withdrawal together: one release only
        done = 1'b1;
        req  = 4'b0000;
        tick();
        check_out("dual_release", 4'b0000, 2'd0, 1'b1);
        check_state("dual_release_state", RELEASE);
        tick();
        check_out("dual_idle", 4'b0000, 2'd0, 1'b0);
        check_state("dual_idle_state", IDLE);
        // done while idle is ignored
        tick();
        check_out("done_idle_ignored", 4'b0000, 2'd0, 1'b0);
        check_state("done_idle_state", IDLE);
        done = 1'b0;

        // Fairness: all requesting from ptr=0, order 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        while (exp_q.size() > 0) begin
            logic [IDW-1:0] e;
            e = exp_q.pop_front();
            tick();
            check_out("rr_grant", onehot(int'(e)), e, 1'b1);
            done = 1'b1;
            tick();
            check_out("rr_release", 4'b0000, 2'd0, 1'b1);
            done = 1'b0;
            tick();
            check_out("rr_idle", 4'b0000, 2'd0, 1'b0);
        end

        // Withdrawal: owner 1 drops req at k, requester 2 granted at k+3
        req = 4'b0110;
        tick();
        check_out("wd_grant1", onehot(1), 2'd1, 1'b1);
        tick();
        check_out("wd_hold1", onehot(1), 2'd1, 1'b1);
        req = 4'b0100;
        tick();
        check_out("wd_k1", 4'b0000, 2'd0, 1'b1);
        tick();
        check_out("wd_k2", 4'b0000, 2'd0, 1'b0);
        tick();
        check_out("wd_k3_grant2", onehot(2), 2'd2, 1'b1);
        // Other requests ignored while owned
        req = 4'b1111;
        tick();
        check_out("own_ignores_others", onehot(2), 2'd2, 1'b1);
        req = 4'b0000;
        tick();
        check_out("wd_final_release", 4'b0000, 2'd0, 1'b1);

        // Long ownership by requester 0 with done low
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0001;
`ifdef ARB_HOLD_LIMIT_EN
        for (int i = 0; i < HOLD_MAX; i++) begin
            tick();
            check_out("hold_owned", onehot(0), 2'd0, 1'b1);
        end
        tick();
        check_out("hold_forced_release", 4'b0000, 2'd0, 1'b1);
        tick();
        check_out("hold_idle", 4'b0000, 2'd0, 1'b0);
        tick();
        check_out("hold_regrant", onehot(0), 2'd0, 1'b1);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            check_out("hold_unbounded", onehot(0), 2'd0, 1'b1);
        end
`endif
        req = 4'b0000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
